// File: rtl/piece_queue.sv
// Tetris piece FIFO: buffers legal LFSR indices and presents a spawn head plus a
// preview entry. Optional feature macro: PIECE_NO_REPEAT_EN (reject one immediate repeat).
module piece_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [2:0]    rand_in,
  input  logic          req,
  output logic          piece_valid,
  output logic [2:0]    piece_type,
  output logic [15:0]   piece_mask,
  output logic          next_valid,
  output logic [2:0]    next_type,
  output logic [CW-1:0] count,
  output logic          filling
);

  typedef enum logic {FILL, READY} stateType;

  stateType      stateQ, stateNext;
  logic [2:0]    entryQ    [DEPTH];
  logic [2:0]    entryNext [DEPTH];
  logic [CW-1:0] countQ, countNext;
  logic [CW-1:0] wrIdx;
  logic          sampleSeen;
  logic          accepted;
  logic          doEnq;
  logic          doPop;

  function automatic logic [15:0] maskOf(input logic [2:0] pieceIdx);
    case (pieceIdx)
      3'd0:    maskOf = 16'h0F00;
      3'd1:    maskOf = 16'h6600;
      3'd2:    maskOf = 16'h4E00;
      3'd3:    maskOf = 16'h6C00;
      3'd4:    maskOf = 16'hC600;
      3'd5:    maskOf = 16'h2E00;
      default: maskOf = 16'h0000;
    endcase
  endfunction

  // A sample is only considered while filling with room left; indices 6/7 are dropped.
  assign sampleSeen = (stateQ == FILL) && (rand_in <= 3'd5) && (countQ < CW'(DEPTH));
  assign doEnq      = sampleSeen && accepted;
  assign doPop      = req && (countQ != '0);
  assign wrIdx      = doPop ? countQ - CW'(1) : countQ;

`ifdef PIECE_NO_REPEAT_EN
  logic [2:0] lastAccepted;
  logic       retryPending;

  // A repeat of the last accepted piece is bounced once; a second repeat goes through.
  assign accepted = !((rand_in == lastAccepted) && !retryPending);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lastAccepted <= 3'd7;
      retryPending <= 1'b0;
    end else if (sampleSeen) begin
      if (accepted) begin
        lastAccepted <= rand_in;
        retryPending <= 1'b0;
      end else begin
        retryPending <= 1'b1;
      end
    end
  end
`else
  assign accepted = 1'b1;
`endif

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    entryNext = entryQ;
    if (doPop) begin
      for (int i = 0; i < DEPTH - 1; i++) entryNext[i] = entryQ[i+1];
      entryNext[DEPTH-1] = 3'd0;
    end
    if (doEnq) begin
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) == wrIdx) entryNext[i] = rand_in;
    end
  end

  always_comb begin
    countNext = countQ;
    case ({doEnq, doPop})
      2'b10:   countNext = countQ + CW'(1);
      2'b01:   countNext = countQ - CW'(1);
      default: countNext = countQ;
    endcase
  end

  // READY exactly while the queue is full; a pop drops straight back to FILL.
  always_comb begin
    stateNext = (countNext == CW'(DEPTH)) ? READY : FILL;
  end

  // NOTE: the entry array is small and must read as type 0 after reset, so it is reset
  // alongside the control state rather than left as an unreset memory.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stateQ <= FILL;
      countQ <= '0;
      for (int i = 0; i < DEPTH; i++) entryQ[i] <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      stateQ <= stateNext;
      countQ <= countNext;
      entryQ <= entryNext;
    end
  end

  always_comb begin
    filling     = (stateQ == FILL);
    count       = countQ;
    piece_valid = (countQ != '0);
    next_valid  = (countQ > CW'(1));
    piece_type  = entryQ[0];
    next_type   = entryQ[1];
    piece_mask  = piece_valid ? maskOf(entryQ[0]) : 16'h0000;
  end

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: fill, pop, illegal samples, pop+enqueue, empty pop,
// asynchronous reset mid-pop and the optional repeat filter.
module tb_piece_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clock;
  logic          resetn;
  logic [2:0]    rand_in;
  logic          req;
  logic          piece_valid;
  logic [2:0]    piece_type;
  logic [15:0]   piece_mask;
  logic          next_valid;
  logic [2:0]    next_type;
  logic [CW-1:0] count;
  logic          filling;

  int passCount  = 0;
  int checkCount = 0;

  piece_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .rand_in     (rand_in),
    .req         (req),
    .piece_valid (piece_valid),
    .piece_type  (piece_type),
    .piece_mask  (piece_mask),
    .next_valid  (next_valid),
    .next_type   (next_type),
    .count       (count),
    .filling     (filling)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Apply inputs for one clock edge, then settle 1 time unit past the edge.
  task automatic step(input logic [2:0] sample, input logic pop);
    rand_in = sample;
    req     = pop;
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn  = 1'b0;
    rand_in = 3'd7;
    req     = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(piece_valid), 32'd0);
    check("rst_mask", 32'(piece_mask), 32'h0);
    check("rst_next_valid", 32'(next_valid), 32'd0);
    check("rst_filling", 32'(filling), 32'd1);
    step(3'd7, 1'b0);
    step(3'd7, 1'b0);
    resetn = 1'b1;

    // Fill with 2,4,1,5 on consecutive cycles.
    step(3'd2, 1'b0);
    check("first_valid", 32'(piece_valid), 32'd1);
    check("first_count", 32'(count), 32'd1);
    step(3'd4, 1'b0);
    step(3'd1, 1'b0);
    step(3'd5, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_filling", 32'(filling), 32'd0);
    check("full_type", 32'(piece_type), 32'd2);
    check("full_mask", 32'(piece_mask), 32'h4E00);
    check("full_next", 32'(next_type), 32'd4);
    step(3'd3, 1'b0);
    check("ready_no_sample", 32'(count), 32'd4);

    // Pop from full, then refill with 0.
    step(3'd7, 1'b1);
    check("pop_type", 32'(piece_type), 32'd4);
    check("pop_mask", 32'(piece_mask), 32'hC600);
    check("pop_count", 32'(count), 32'd3);
    check("pop_filling", 32'(filling), 32'd1);
    check("pop_next", 32'(next_type), 32'd1);
    step(3'd0, 1'b0);
    check("refill_count", 32'(count), 32'd4);
    check("refill_filling", 32'(filling), 32'd0);

    // Drain three to expose queue order 1,5,0 (tail 0).
    step(3'd7, 1'b1);
    check("drain1_type", 32'(piece_type), 32'd1);
    step(3'd7, 1'b1);
    check("drain2_type", 32'(piece_type), 32'd5);
    check("drain2_next", 32'(next_type), 32'd0);
    step(3'd7, 1'b1);
    check("tail_type", 32'(piece_type), 32'd0);
    check("tail_mask", 32'(piece_mask), 32'h0F00);
    check("tail_next_valid", 32'(next_valid), 32'd0);

    // Count=2 then pop and enqueue together.
    step(3'd3, 1'b0);
    check("pre_both_count", 32'(count), 32'd2);
    step(3'd1, 1'b1);
    check("both_count", 32'(count), 32'd2);
    check("both_type", 32'(piece_type), 32'd3);
    check("both_next", 32'(next_type), 32'd1);
    check("both_next_valid", 32'(next_valid), 32'd1);

    // Drain to empty, then request on empty.
    step(3'd7, 1'b1);
    step(3'd7, 1'b1);
    check("empty_count", 32'(count), 32'd0);
    step(3'd7, 1'b1);
    check("empty_req_count", 32'(count), 32'd0);
    check("empty_req_valid", 32'(piece_valid), 32'd0);
    check("empty_req_mask", 32'(piece_mask), 32'h0);

    // Illegal samples are discarded.
    step(3'd6, 1'b0);
    step(3'd7, 1'b0);
    step(3'd7, 1'b0);
    check("illegal_count", 32'(count), 32'd0);
    step(3'd3, 1'b0);
    check("legal_count", 32'(count), 32'd1);
    check("legal_mask", 32'(piece_mask), 32'h6C00);
    check("legal_next_valid", 32'(next_valid), 32'd0);

    // Reset asserted while a pop is pending with count=3.
    step(3'd2, 1'b0);
    step(3'd4, 1'b0);
    check("prerst_count", 32'(count), 32'd3);
    rand_in = 3'd7;
    req     = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_valid", 32'(piece_valid), 32'd0);
    check("midrst_type", 32'(piece_type), 32'd0);
    check("midrst_mask", 32'(piece_mask), 32'h0);
    check("midrst_next_valid", 32'(next_valid), 32'd0);
    check("midrst_next_type", 32'(next_type), 32'd0);
    step(3'd7, 1'b1);
    check("midrst_hold_count", 32'(count), 32'd0);
    req    = 1'b0;
    resetn = 1'b1;

    // Repeat filter: 3,3,3 from empty.
    step(3'd3, 1'b0);
    step(3'd3, 1'b0);
    step(3'd3, 1'b0);
`ifdef PIECE_NO_REPEAT_EN
    check("repeat_count", 32'(count), 32'd2);
    check("repeat_next_valid", 32'(next_valid), 32'd1);
`else
    check("repeat_count", 32'(count), 32'd3);
    check("repeat_next_valid", 32'(next_valid), 32'd1);
`endif
    check("repeat_type", 32'(piece_type), 32'd3);
    check("repeat_next", 32'(next_type), 32'd3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/piece_queue.md
Name: piece_queue

Overview:
- Downstream consumer of the 3-bit LFSR piece index (values 0..5).
- Buffers a short FIFO of upcoming Tetris pieces so the game FSM always has a spawn piece and a preview piece available.
- Converts each index into its 4x4 spawn bitmap.
- Pops the head entry on a single-cycle request from the game control FSM.

Parameters:
- DEPTH, 4: queue entries (2..8); entry 0 is the spawn head, entry 1 is the preview.
- CW, 3: count width, must hold 0..DEPTH.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- rand_in  in  3  LFSR output; sampled every cycle while filling.
- req  in  1  pop request from game FSM, one cycle per piece.
- piece_valid  out  1  head entry is valid.
- piece_type  out  3  head piece index.
- piece_mask  out  16  head 4x4 spawn bitmap; bit 15 = row0/col0, row-major.
- next_valid  out  1  preview entry is valid.
- next_type  out  3  preview piece index.
- count  out  CW  number of valid entries.
- filling  out  1  FSM is in FILL state.

Behaviour:
- Reset (resetn low, asynchronous):
  - count=0, all entries cleared to type 0.
  - piece_valid=0, next_valid=0, piece_type=0, piece_mask=0, next_type=0.
  - FSM=FILL, last_accepted=7 (none).
- Encoding: 0 I=0x0F00, 1 O=0x6600, 2 T=0x4E00, 3 S=0x6C00, 4 Z=0xC600, 5 L=0x2E00.
  - piece_mask is a pure function of the registered head type.
  - piece_mask is forced to 0 when piece_valid=0.
- Legal sample: rand_in <= 5. Values 6 and 7 are discarded and never enqueued.
- FSM states:
  - FILL: each cycle with a legal sample and count<DEPTH, the sample is written at tail and count increments.
    - Go to READY in the cycle count becomes DEPTH.
  - READY: no sampling.
    - Go to FILL on the cycle after a pop leaves count<DEPTH.
- Pop:
  - Occurs when req=1 and piece_valid=1 at a clock edge.
  - Entries shift toward the head; the new head/preview are visible the next cycle, so pop latency is 1 cycle.
  - A req while piece_valid=0 is ignored; there is no queuing of requests.
- Simultaneous pop and enqueue in FILL:
  - The shift and the tail write occur in the same edge; count is unchanged.
  - The new sample lands at index count-1 after the shift.
- Pop when count=DEPTH in READY:
  - count becomes DEPTH-1 and the FSM enters FILL next cycle.
  - At most one cycle without sampling.
- Derived outputs:
  - piece_valid = (count>=1); next_valid = (count>=2).
  - filling = (state==FILL).
- Empty boundary:
  - After reset the head becomes valid 1 cycle after the first legal sample.
  - DEPTH legal samples on consecutive cycles fill the queue in DEPTH cycles.
- Reset mid-operation clears everything immediately, including during a pop.
- The count never exceeds DEPTH and never underflows below 0.

Optional Feature:
- Macro: PIECE_NO_REPEAT_EN.
- Defined:
  - A legal sample equal to last_accepted is rejected once (one retry).
  - If the next legal sample also equals last_accepted, it is accepted and the retry flag clears.
  - Any accepted sample updates last_accepted and clears the retry flag.
  - last_accepted resets to 7.
- Undefined: every legal sample is accepted; no retry logic is present.

Test Plan:
- Reset, then rand_in=2,4,1,5 on consecutive cycles:
  - count reaches 4, filling drops to 0.
  - piece_type=2, piece_mask=0x4E00, next_type=4.
- Full queue 2,4,1,5; pulse req one cycle:
  - Next cycle piece_type=4, piece_mask=0xC600, count=3, filling=1.
  - rand_in=0 then yields count=4 and tail=0.
- Drive rand_in=6,7,7,3 from empty:
  - Only 3 enqueued; count=1, piece_mask=0x6C00, next_valid=0.
- Count=2 in FILL, req=1 with rand_in=1 in the same cycle:
  - count stays 2, head is the old preview, preview=1.
- Assert req with count=0:
  - No change; piece_valid=0, piece_mask=0.
  - Deassert resetn mid-pop with count=3: all outputs go 0 immediately.
- With PIECE_NO_REPEAT_EN, from empty drive rand_in=3,3,3:
  - Queue holds 3,3 (second rejected, third accepted); count=2.
  - Without the macro, count=3.
